cru_strobe_sync: RTL

//  Upstream front end for the CRU bit register. Brings the asynchronous TI CRU write cycle into the

---
 rtl/cru_strobe_sync.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cru_strobe_sync.sv
// Resynchronises the asynchronous TI CRU write cycle into the card clock domain and emits one decoded write pulse per accepted strobe.
// Optional glitch filter on the synced CRU clock is enabled by defining CRU_GLITCH_FILTER_EN.
module cru_strobe_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:3]  cru_base,
  input  logic        ti_cru_clk,
  input  logic        ti_memen,
  input  logic [0:14] addr,
  input  logic        ti_cru_out,
  output logic        wr_strobe,
  output logic [1:0]  wr_bit,
  output logic        wr_data,
  output logic        card_sel,
  output logic [7:0]  miss_count
);

  if (SYNC_STAGES < 2 || FILTER_CYCLES < 1 || FILTER_CYCLES > 15) begin : g_bad_params
    $error("cru_strobe_sync: SYNC_STAGES must be >= 2 and FILTER_CYCLES in 1..15");
  end

  typedef enum logic [1:0] {ARM, IDLE, LOW, FIRE} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, memen_sync_q, data_sync_q, flush_q;
  logic [0:14]            addr_sync_q [SYNC_STAGES];

  logic        sclk, smemen, sdata, flushed, match, capture;
  logic [0:14] saddr;

  state_t state_q, state_d;
  logic       cap_match_q, cap_data_q;
  logic [1:0] cap_bit_q;
  logic       wr_strobe_q, wr_data_q, card_sel_q;
  logic [1:0] wr_bit_q;
  logic [7:0] miss_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q   <= '1;
      memen_sync_q <= '1;
      data_sync_q  <= '0;
      flush_q      <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) addr_sync_q[i] <= '0;
    end else begin
      clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], ti_cru_clk};
      memen_sync_q <= {memen_sync_q[SYNC_STAGES-2:0], ti_memen};
      data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], ti_cru_out};
      flush_q      <= {flush_q[SYNC_STAGES-2:0], 1'b1};
      addr_sync_q[0] <= addr;
      for (int i = 1; i < SYNC_STAGES; i++) addr_sync_q[i] <= addr_sync_q[i-1];
    end
  end

  assign sclk   = clk_sync_q[SYNC_STAGES-1];
  assign smemen = memen_sync_q[SYNC_STAGES-1];
  assign sdata  = data_sync_q[SYNC_STAGES-1];
  assign saddr  = addr_sync_q[SYNC_STAGES-1];
  // The reset-filled 1s are not a real high phase; ARM only trusts sclk once the chain has flushed.
  assign flushed = flush_q[SYNC_STAGES-1];

  assign match = (saddr[0:3] == 4'b0001) && (saddr[4:7] == cru_base) &&
                 (saddr[8:12] == 5'd0) && smemen;

`ifdef CRU_GLITCH_FILTER_EN
  localparam logic [3:0] CNT_TARGET = 4'(FILTER_CYCLES);
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
`ifdef CRU_GLITCH_FILTER_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      ARM:  if (sclk && flushed) state_d = IDLE;
      IDLE: if (!sclk) begin
`ifdef CRU_GLITCH_FILTER_EN
        cnt_d = 4'd1;
        if (FILTER_CYCLES == 1) begin
          state_d = FIRE;
          capture = 1'b1;
        end else begin
          state_d = LOW;
        end
`else
        state_d = FIRE;
        capture = 1'b1;
`endif
      end
`ifdef CRU_GLITCH_FILTER_EN
      LOW: begin
        if (sclk) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == CNT_TARGET) begin
            state_d = FIRE;
            capture = 1'b1;
          end
        end
      end
`endif
      FIRE:    state_d = ARM;
      default: state_d = ARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARM;
      cap_match_q <= 1'b0;
      cap_data_q  <= 1'b0;
      cap_bit_q   <= '0;
      wr_strobe_q <= 1'b0;
      wr_bit_q    <= '0;
      wr_data_q   <= 1'b0;
      card_sel_q  <= 1'b0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_strobe_q <= (state_q == FIRE) && cap_match_q;
      if (capture) begin
        cap_match_q <= match;
        cap_data_q  <= sdata;
        cap_bit_q   <= {saddr[13], saddr[14]};
      end
      if (state_q == FIRE) begin
        card_sel_q <= cap_match_q;
        if (cap_match_q) begin
          wr_bit_q  <= cap_bit_q;
          wr_data_q <= cap_data_q;
        end else if (miss_q != 8'hFF) begin
          miss_q <= miss_q + 8'd1;
        end
      end
    end
  end

  assign wr_strobe  = wr_strobe_q;
  assign wr_bit     = wr_bit_q;
  assign wr_data    = wr_data_q;
  assign card_sel   = card_sel_q;
  assign miss_count = miss_q;

endmodule
